fp32_mul_seq: RTL

Multi-cycle IEEE-754 single-precision multiplier that consumes the operand pair assembled by the peripherals unit and returns its product as `dataR` for the seven-segment result display. It uses a shift-add mantissa datapath (one partial product per cycle) to keep area small on the lab FPGA. A `start`/`done` handshake brackets each operation. Integration drives `start` from the rising edge of `inputdata_ready`.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fp_mant_mul_seq.sv | 61 ++++++
 rtl/fp32_mul_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fp32 multiplier: FSM state type, fp32 constants and
// operand classification helpers.
package fpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StMul,
        StNorm,
        StDone
    } fmul_state_t;

    localparam logic [31:0]        FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]        FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0]        FP_NEG_INF = 32'hFF80_0000;
    localparam logic signed [9:0]  FP_BIAS    = 10'sd127;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

endpackage

// File: rtl/fp_mant_mul_seq.sv
// Shift-add significand multiplier: one partial product per step, MANT_W steps total.
module fp_mant_mul_seq #(
    parameter int unsigned MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [MANT_W-1:0]     multiplicand,
    input  logic [MANT_W-1:0]     multiplier,
    output logic [2*MANT_W-1:0]   product,
    output logic                  last
);

    localparam logic [4:0] LastCnt = 5'(MANT_W - 1);

    logic [2*MANT_W-1:0] mcand_q, mcand_d;
    logic [2*MANT_W-1:0] acc_q, acc_d;
    logic [MANT_W-1:0]   mplr_q, mplr_d;
    logic [4:0]          cnt_q, cnt_d;

    // The multiplicand register shifts left each step, so it always holds
    // multiplicand << cnt when its partial product is considered.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        if (load) begin
            mcand_d = {{MANT_W{1'b0}}, multiplicand};
            mplr_d  = multiplier;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (step) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = acc_q;
    assign last    = (cnt_q == LastCnt);

endmodule

// File: rtl/fp32_mul_seq.sv
// Multi-cycle fp32 multiplier with start/done handshake; specials resolve in CHECK,
// normal operands go through the shift-add datapath and a truncating normalise.
module fp32_mul_seq
    import fpu_pkg::*;
#(
    parameter int unsigned MANT_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] dataR,
    output logic        busy,
    output logic        done
);

    fmul_state_t        state_q, state_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [31:0]        data_r_q, data_r_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic                  mant_load, mant_step, mant_last;
    logic [2*MANT_W-1:0]   product;
    logic                  s;
    logic signed [9:0]     e_norm;
    logic [22:0]           mant;
    logic                  unused_product_lo;

    assign s = op_a_q[31] ^ op_b_q[31];
    assign unused_product_lo = ^product[22:0];

    fp_mant_mul_seq #(
        .MANT_W(MANT_W)
    ) u_mant (
        .clk         (clk),
        .reset       (reset),
        .load        (mant_load),
        .step        (mant_step),
        .multiplicand({1'b1, op_a_q[22:0]}),
        .multiplier  ({1'b1, op_b_q[22:0]}),
        .product     (product),
        .last        (mant_last)
    );

    // Product of two [1,2) significands lies in [1,4); bit 47 flags the [2,4) half.
    always_comb begin
        if (product[47]) begin
            mant   = product[46:24];
            e_norm = exp_q + 10'sd1;
        end else begin
            mant   = product[45:23];
            e_norm = exp_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        data_r_d  = data_r_q;
        done_d    = 1'b0;
        mant_load = 1'b0;
        mant_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_a_d  = dataA;
                    op_b_d  = dataB;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                sign_d  = s;
                state_d = StDone;
                done_d  = 1'b1;
                if (is_nan(op_a_q) || is_nan(op_b_q)) begin
                    data_r_d = FP_QNAN;
                end else if ((is_inf(op_a_q) && is_zero(op_b_q)) ||
                             (is_inf(op_b_q) && is_zero(op_a_q))) begin
                    data_r_d = {s, 8'hFF, 1'b1, 22'd0};
                end else if (is_inf(op_a_q) || is_inf(op_b_q)) begin
                    data_r_d = s ? FP_NEG_INF : FP_POS_INF;
                end else if ((op_a_q[30:23] == 8'd0) || (op_b_q[30:23] == 8'd0)) begin
                    data_r_d = {s, 31'd0};
                end else begin
                    mant_load = 1'b1;
                    exp_d     = $signed({2'b00, op_a_q[30:23]}) +
                                $signed({2'b00, op_b_q[30:23]}) - FP_BIAS;
                    state_d   = StMul;
                    done_d    = 1'b0;
                end
            end
            StMul: begin
                mant_step = 1'b1;
                if (mant_last) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (e_norm >= 10'sd255) begin
                    data_r_d = sign_q ? FP_NEG_INF : FP_POS_INF;
                end else if (e_norm <= 10'sd0) begin
                    data_r_d = {sign_q, 31'd0};
                end else begin
                    data_r_d = {sign_q, e_norm[7:0], mant};
                end
                state_d = StDone;
                done_d  = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            data_r_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            data_r_q <= data_r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dataR = data_r_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
